// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with a prefetch buffer.
// Issues pipelined AXI-Lite reads ahead of decode and holds up to DEPTH
// requests in flight or buffered. Entries reach the IDU in order as {pc, inst, fault}.
//
// state  | meaning
// IDLE   | no AR outstanding on the bus; issue once a credit is free and not halted
// REQ    | AR valid with a held address, waiting for ar_ready
module ifu_prefetch #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INST_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter int                 PC_STEP  = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              f_valid_o,
   input  logic              D_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              fault_o,
   output logic              mst_ar_valid_o,
   output logic [ADDR_W-1:0] mst_ar_addr_o,
   input  logic              mst_ar_ready_i,
   input  logic              mst_r_valid_i,
   input  logic [INST_W-1:0] mst_r_data_i,
   input  logic [1:0]        mst_r_resp_i,
   output logic              mst_r_ready_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic              stale_q, stale_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] rpc_q, rpc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              halted_q, halted_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic              mem_flt  [DEPTH];

   logic              ar_hs, r_hs, push, pop, empty, full;
   logic [CNT_W:0]    credit_sum;

   assign ar_hs      = (state_q == S_REQ) && mst_ar_ready_i;
   assign mst_r_ready_o = (inflight_q != '0) || (drop_q != '0);
   assign r_hs       = mst_r_valid_i && mst_r_ready_o;
   // Beats owed to a flushed stream, or arriving during a redirect, are discarded.
   assign push       = r_hs && (drop_q == '0) && !redirect_i;
   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign pop        = !empty && D_ready_i && !redirect_i;
   assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q} + {1'b0, drop_q};

   assign mst_ar_valid_o = (state_q == S_REQ);
   assign mst_ar_addr_o  = ar_addr_q;
   assign f_valid_o      = !empty;
   assign pc_o           = empty ? '0 : mem_pc[rd_ptr_q];
   assign inst_o         = empty ? '0 : mem_inst[rd_ptr_q];
   assign fault_o        = empty ? 1'b0 : mem_flt[rd_ptr_q];

   // Issue FSM, fetch/response PCs and credit counters.
   always_comb begin
      state_d    = state_q;
      ar_addr_d  = ar_addr_q;
      stale_d    = stale_q;
      fpc_d      = fpc_q;
      rpc_d      = rpc_q;
      halted_d   = halted_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;

      case (state_q)
         S_IDLE: begin
            if (!halted_q && (credit_sum < (CNT_W+1)'(DEPTH))) begin
               state_d   = S_REQ;
               ar_addr_d = redirect_i ? redirect_pc_i : fpc_q;
            end
         end
         S_REQ: begin
            if (ar_hs) begin
               state_d = S_IDLE;
               stale_d = 1'b0;
            end else if (redirect_i) begin
               stale_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stale request was issued at the old stream, so it does not advance fpc.
      if (redirect_i)
         fpc_d = redirect_pc_i;
      else if (ar_hs && !stale_q)
         fpc_d = fpc_q + ADDR_W'(PC_STEP);

      if (r_hs) begin
         if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
         else              inflight_d = inflight_q - CNT_W'(1);
      end
      if (redirect_i) begin
         drop_d     = drop_d + inflight_d;
         inflight_d = '0;
      end
      if (ar_hs) begin
         if (stale_q || redirect_i) drop_d = drop_d + CNT_W'(1);
         else                       inflight_d = inflight_d + CNT_W'(1);
      end

      if (redirect_i) begin
         rpc_d    = redirect_pc_i;
         halted_d = 1'b0;
      end else if (push) begin
         rpc_d = rpc_q + ADDR_W'(PC_STEP);
         if (mst_r_resp_i != 2'b00) halted_d = 1'b1;
      end
   end

   // Prefetch FIFO pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ar_addr_q  <= '0;
         stale_q    <= 1'b0;
         fpc_q      <= RESET_PC;
         rpc_q      <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         ar_addr_q  <= ar_addr_d;
         stale_q    <= stale_d;
         fpc_q      <= fpc_d;
         rpc_q      <= rpc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Buffer storage; contents are masked by the empty flag, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= rpc_q;
         mem_inst[wr_ptr_q] <= mst_r_data_i;
         mem_flt[wr_ptr_q]  <= (mst_r_resp_i != 2'b00);
      end
   end

   // Credits reserve a slot for every response, so a push can never hit a full buffer.
   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a latency-configurable AXI-Lite read slave.
module tb_ifu_prefetch;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        f_valid_o;
   logic        D_ready_i = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        fault_o;
   logic        mst_ar_valid_o;
   logic [31:0] mst_ar_addr_o;
   logic        mst_ar_ready_i = 1'b0;
   logic        mst_r_valid_i;
   logic [31:0] mst_r_data_i;
   logic [1:0]  mst_r_resp_i;
   logic        mst_r_ready_o;

   int vectors = 0;
   int miscompares = 0;

   int          r_lat = 0;
   logic [31:0] fault_addr = 32'hFFFF_FFFF;

   logic [31:0] sq_addr[$];
   int          sq_due[$];
   int          scyc;

   int          cyc;
   logic [31:0] ar_log[$];
   int          ar_cyc[$];
   int          rhs_cyc[$];
   logic [31:0] dec_pc[$];
   logic [31:0] dec_inst[$];
   logic        dec_flt[$];
   int          pop_cyc[$];

   ifu_prefetch dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .f_valid_o(f_valid_o), .D_ready_i(D_ready_i),
      .pc_o(pc_o), .inst_o(inst_o), .fault_o(fault_o),
      .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o),
      .mst_ar_ready_i(mst_ar_ready_i),
      .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i),
      .mst_r_resp_i(mst_r_resp_i), .mst_r_ready_o(mst_r_ready_o)
   );

   always #5 clk_i = ~clk_i;

   // Read slave: in-order responses r_lat cycles after the AR handshake; data = ~addr.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sq_addr.delete();
         sq_due.delete();
         scyc = 0;
         mst_r_valid_i <= 1'b0;
         mst_r_data_i  <= '0;
         mst_r_resp_i  <= '0;
      end else begin
         if (mst_r_valid_i && mst_r_ready_o) begin
            void'(sq_addr.pop_front());
            void'(sq_due.pop_front());
         end
         if (mst_ar_valid_o && mst_ar_ready_i) begin
            sq_addr.push_back(mst_ar_addr_o);
            sq_due.push_back(scyc + 1 + r_lat);
         end
         if (sq_addr.size() > 0 && sq_due[0] <= scyc + 1) begin
            mst_r_valid_i <= 1'b1;
            mst_r_data_i  <= ~sq_addr[0];
            mst_r_resp_i  <= (sq_addr[0] == fault_addr) ? 2'b10 : 2'b00;
         end else begin
            mst_r_valid_i <= 1'b0;
         end
         scyc++;
      end
   end

   // Bus and decode-side monitor.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         cyc++;
         if (mst_ar_valid_o && mst_ar_ready_i) begin
            ar_log.push_back(mst_ar_addr_o);
            ar_cyc.push_back(cyc);
         end
         if (mst_r_valid_i && mst_r_ready_o) rhs_cyc.push_back(cyc);
         if (f_valid_o && D_ready_i) begin
            dec_pc.push_back(pc_o);
            dec_inst.push_back(inst_o);
            dec_flt.push_back(fault_o);
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic do_reset(input int lat, input logic [31:0] faddr, input logic drdy);
      @(negedge clk_i);
      rst_i = 1'b1;
      redirect_i = 1'b0;
      mst_ar_ready_i = 1'b1;
      D_ready_i = drdy;
      r_lat = lat;
      fault_addr = faddr;
      cyc = 0;
      ar_log.delete(); ar_cyc.delete(); rhs_cyc.delete();
      dec_pc.delete(); dec_inst.delete(); dec_flt.delete(); pop_cyc.delete();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      logic [31:0] bus;
      bus = {f_valid_o, fault_o, mst_ar_valid_o, mst_r_ready_o};
      vectors++;
      if (bus !== 32'd0) begin
         miscompares++;
         $display("FAIL %s flags: got %h want 0", tag, bus);
      end
      vectors++;
      if ((pc_o | inst_o | mst_ar_addr_o) !== 32'd0) begin
         miscompares++;
         $display("FAIL %s buses: pc %h inst %h ar %h want 0", tag, pc_o, inst_o, mst_ar_addr_o);
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_pc_i = pc;
      redirect_i = 1'b1;
      @(negedge clk_i);
      redirect_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      #3;
      check_outputs_zero("reset");
   endtask

   task automatic test_stream;
      do_reset(0, 32'hFFFF_FFFF, 1'b1);
      repeat (30) @(negedge clk_i);
      vectors++;
      if (ar_log.size() < 6 || dec_pc.size() < 5) begin
         miscompares++;
         $display("FAIL stream_count: ar %0d dec %0d want >=6/>=5", ar_log.size(), dec_pc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ar_log[i] !== 32'h8000_0000 + 32'(4 * i)) begin
               miscompares++;
               $display("FAIL stream_ar[%0d]: got %h want %h", i, ar_log[i], 32'h8000_0000 + 32'(4 * i));
            end
            vectors++;
            if (dec_pc[i] !== 32'h8000_0000 + 32'(4 * i) || dec_inst[i] !== ~(32'h8000_0000 + 32'(4 * i)) || dec_flt[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL stream_dec[%0d]: got pc %h inst %h flt %b", i, dec_pc[i], dec_inst[i], dec_flt[i]);
            end
            vectors++;
            if (pop_cyc[i] !== rhs_cyc[i] + 1) begin
               miscompares++;
               $display("FAIL stream_latency[%0d]: pop at %0d want %0d", i, pop_cyc[i], rhs_cyc[i] + 1);
            end
            vectors++;
            if (ar_cyc[i + 1] - ar_cyc[i] !== 2) begin
               miscompares++;
               $display("FAIL stream_ar_spacing[%0d]: got %0d want 2", i, ar_cyc[i + 1] - ar_cyc[i]);
            end
         end
      end
   endtask

   task automatic test_full;
      do_reset(0, 32'hFFFF_FFFF, 1'b0);
      repeat (20) @(negedge clk_i);
      vectors++;
      if (ar_log.size() !== 4 || f_valid_o !== 1'b1 || mst_ar_valid_o !== 1'b0 || pc_o !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL full_stall: ar %0d fv %b arv %b pc %h want 4/1/0/80000000",
                  ar_log.size(), f_valid_o, mst_ar_valid_o, pc_o);
      end
      D_ready_i = 1'b1;
      @(negedge clk_i);
      D_ready_i = 1'b0;
      repeat (10) @(negedge clk_i);
      vectors++;
      if (ar_log.size() !== 5) begin
         miscompares++;
         $display("FAIL full_refill_count: got %0d want 5", ar_log.size());
      end else begin
         vectors++;
         if (ar_log[4] !== 32'h8000_0010) begin
            miscompares++;
            $display("FAIL full_refill_addr: got %h want 80000010", ar_log[4]);
         end
      end
      vectors++;
      if (pc_o !== 32'h8000_0004 || inst_o !== ~32'h8000_0004 || mst_ar_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL full_head: pc %h inst %h arv %b want 80000004/7ffffffb/0", pc_o, inst_o, mst_ar_valid_o);
      end
   endtask

   task automatic test_redirect_inflight;
      int n;
      do_reset(5, 32'hFFFF_FFFF, 1'b1);
      n = 0;
      while (ar_log.size() < 3 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      vectors++;
      if (ar_log.size() !== 3 || rhs_cyc.size() !== 0) begin
         miscompares++;
         $display("FAIL redir_setup: ar %0d rhs %0d want 3/0", ar_log.size(), rhs_cyc.size());
      end
      do_redirect(32'h8000_1000);
      repeat (30) @(negedge clk_i);
      vectors++;
      if (ar_log.size() < 4 || dec_pc.size() < 1) begin
         miscompares++;
         $display("FAIL redir_progress: ar %0d dec %0d want >=4/>=1", ar_log.size(), dec_pc.size());
      end else begin
         vectors++;
         if (ar_log[3] !== 32'h8000_1000) begin
            miscompares++;
            $display("FAIL redir_ar: got %h want 80001000", ar_log[3]);
         end
         vectors++;
         if (dec_pc[0] !== 32'h8000_1000 || dec_inst[0] !== ~32'h8000_1000) begin
            miscompares++;
            $display("FAIL redir_first_dec: pc %h inst %h want 80001000/7fffefff", dec_pc[0], dec_inst[0]);
         end
      end
   endtask

   task automatic test_redirect_pending;
      int n;
      do_reset(0, 32'hFFFF_FFFF, 1'b1);
      n = 0;
      while (ar_log.size() < 2 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      mst_ar_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      vectors++;
      if (mst_ar_valid_o !== 1'b1 || mst_ar_addr_o !== 32'h8000_0008) begin
         miscompares++;
         $display("FAIL pend_before: arv %b addr %h want 1/80000008", mst_ar_valid_o, mst_ar_addr_o);
      end
      do_redirect(32'h8000_0200);
      repeat (2) @(negedge clk_i);
      vectors++;
      if (mst_ar_valid_o !== 1'b1 || mst_ar_addr_o !== 32'h8000_0008) begin
         miscompares++;
         $display("FAIL pend_hold: arv %b addr %h want 1/80000008", mst_ar_valid_o, mst_ar_addr_o);
      end
      mst_ar_ready_i = 1'b1;
      repeat (20) @(negedge clk_i);
      vectors++;
      if (ar_log.size() < 4 || dec_pc.size() < 3) begin
         miscompares++;
         $display("FAIL pend_progress: ar %0d dec %0d want >=4/>=3", ar_log.size(), dec_pc.size());
      end else begin
         vectors++;
         if (ar_log[2] !== 32'h8000_0008 || ar_log[3] !== 32'h8000_0200) begin
            miscompares++;
            $display("FAIL pend_ar_seq: got %h %h want 80000008 80000200", ar_log[2], ar_log[3]);
         end
         vectors++;
         if (dec_pc[1] !== 32'h8000_0004 || dec_pc[2] !== 32'h8000_0200) begin
            miscompares++;
            $display("FAIL pend_dec_seq: got %h %h want 80000004 80000200", dec_pc[1], dec_pc[2]);
         end
      end
   endtask

   task automatic test_fault;
      int n_ar, n_dec;
      do_reset(0, 32'h8000_0004, 1'b1);
      repeat (15) @(negedge clk_i);
      n_ar = ar_log.size();
      repeat (10) @(negedge clk_i);
      vectors++;
      if (ar_log.size() !== n_ar || mst_ar_valid_o !== 1'b0 || n_ar > 3) begin
         miscompares++;
         $display("FAIL fault_halt: ar %0d then %0d arv %b want stable <=3, arv 0",
                  n_ar, ar_log.size(), mst_ar_valid_o);
      end
      vectors++;
      if (dec_pc.size() < 2) begin
         miscompares++;
         $display("FAIL fault_dec_count: got %0d want >=2", dec_pc.size());
      end else if (dec_flt[0] !== 1'b0 || dec_pc[1] !== 32'h8000_0004 || dec_flt[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_entry: flt0 %b pc1 %h flt1 %b want 0/80000004/1", dec_flt[0], dec_pc[1], dec_flt[1]);
      end
      n_dec = dec_pc.size();
      do_redirect(32'h8000_0100);
      repeat (20) @(negedge clk_i);
      vectors++;
      if (ar_log.size() <= n_ar || dec_pc.size() <= n_dec) begin
         miscompares++;
         $display("FAIL fault_resume: ar %0d dec %0d want >%0d/>%0d", ar_log.size(), dec_pc.size(), n_ar, n_dec);
      end else if (ar_log[n_ar] !== 32'h8000_0100 || dec_pc[n_dec] !== 32'h8000_0100 || dec_flt[n_dec] !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_resume_addr: ar %h dec %h flt %b want 80000100/80000100/0",
                  ar_log[n_ar], dec_pc[n_dec], dec_flt[n_dec]);
      end
   endtask

   task automatic test_reset_mid;
      do_reset(3, 32'hFFFF_FFFF, 1'b0);
      repeat (9) @(negedge clk_i);
      vectors++;
      if (f_valid_o !== 1'b1 && mst_r_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_busy: fv %b rrdy %b want busy", f_valid_o, mst_r_ready_o);
      end
      #2 rst_i = 1'b1;
      #1 check_outputs_zero("midrst_async");
      cyc = 0;
      ar_log.delete(); ar_cyc.delete(); rhs_cyc.delete();
      dec_pc.delete(); dec_inst.delete(); dec_flt.delete(); pop_cyc.delete();
      D_ready_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (15) @(negedge clk_i);
      vectors++;
      if (ar_log.size() < 1 || dec_pc.size() < 1) begin
         miscompares++;
         $display("FAIL midrst_restart: ar %0d dec %0d want >=1", ar_log.size(), dec_pc.size());
      end else if (ar_log[0] !== 32'h8000_0000 || dec_pc[0] !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL midrst_first: ar %h dec %h want 80000000", ar_log[0], dec_pc[0]);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_inflight();
      test_redirect_pending();
      test_fault();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
